// File: rtl/instr_sequencer_pkg.sv
// rtl/instr_sequencer_pkg.sv - shared processor constants, opcodes and sequencer state encoding
package instr_sequencer_pkg;

  localparam int DW    = 9;
  localparam int OP_W  = 3;
  localparam int OP_HI = DW - 1;
  localparam int OP_LO = DW - OP_W;

  localparam logic [OP_W-1:0] MV_OP  = 3'b000;
  localparam logic [OP_W-1:0] ADD_OP = 3'b001;
  localparam logic [OP_W-1:0] SUB_OP = 3'b010;
  localparam logic [OP_W-1:0] MVI_OP = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    IMM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - program-load, control and processor-facing signals of the sequencer
interface instr_sequencer_if #(
  parameter int DW = instr_sequencer_pkg::DW,
  parameter int AW = 5
);

  logic          Wr_En;
  logic [AW-1:0] Wr_Addr;
  logic [DW-1:0] Wr_Data;
  logic [AW:0]   Prog_Len;
  logic          Start;
  logic          Done;
  logic [DW-1:0] DIN;
  logic          Run;
  logic [AW:0]   PC;
  logic          Busy;
  logic          Prog_Done;
  logic          Error;

  modport master (
    output Wr_En, Wr_Addr, Wr_Data, Prog_Len, Start, Done,
    input  DIN, Run, PC, Busy, Prog_Done, Error
  );

  modport slave (
    input  Wr_En, Wr_Addr, Wr_Data, Prog_Len, Start, Done,
    output DIN, Run, PC, Busy, Prog_Done, Error
  );

endinterface

// File: rtl/instr_store.sv
// rtl/instr_store.sv - register-array program memory, one synchronous write port, one combinational read port
module instr_store #(
  parameter int DW = instr_sequencer_pkg::DW,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Contents are intentionally not reset so a program survives a processor reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues stored 9-bit instructions to the processor, one per Done handshake
module instr_sequencer #(
  parameter int         DW      = instr_sequencer_pkg::DW,
  parameter int         AW      = 5,
  parameter logic [2:0] MVI_OP  = instr_sequencer_pkg::MVI_OP,
  parameter int         TIMEOUT = 16
) (
  input  logic             Clock,
  input  logic             Resetn,
  instr_sequencer_if.slave bus
);

  import instr_sequencer_pkg::*;

  localparam int        CW     = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] PC_ONE = (AW + 1)'(1);
  localparam logic [AW:0] PC_TWO = (AW + 1)'(2);

  state_t        state_q, state_d;
  logic [DW-1:0] din_q, din_d, rd_data;
  logic          run_q, run_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [AW:0]   pc_q, pc_d, len_q, len_d, next_pc;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [AW-1:0] rd_addr;
  logic          is_mvi, is_last, timed_out, start_go, start_nil;

  // next_pc is PC+1 in ISSUE/WAIT (immediate or next instruction) and PC+2 after an immediate.
  assign next_pc   = pc_q + ((state_q == IMM) ? PC_TWO : PC_ONE);
  assign is_last   = next_pc >= len_q;
  assign is_mvi    = din_q[DW-1 -: OP_W] == MVI_OP;
  assign timed_out = tcnt_q == CW'(TIMEOUT - 1);
  assign start_go  = bus.Start && (bus.Prog_Len != '0);
  assign start_nil = bus.Start && (bus.Prog_Len == '0);
  assign rd_addr   = (state_q == IDLE) ? '0 : next_pc[AW-1:0];

  instr_store #(.DW(DW), .AW(AW)) u_store (
    .clk   (Clock),
    .we    (bus.Wr_En && (state_q == IDLE)),
    .waddr (bus.Wr_Addr),
    .wdata (bus.Wr_Data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_go) state_d = ISSUE;
      ISSUE:   state_d = is_mvi ? (is_last ? IDLE : IMM) : WAIT;
      default: begin
        if (bus.Done) state_d = is_last ? IDLE : ISSUE;
        else if (timed_out) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    din_d  = din_q;
    run_d  = run_q;
    pc_d   = pc_q;
    len_d  = len_q;
    tcnt_d = '0;
    done_d = 1'b0;
    err_d  = err_q;
    case (state_q)
      IDLE: begin
        if (start_nil) begin
          done_d = 1'b1;
          err_d  = 1'b0;
        end else if (start_go) begin
          len_d = bus.Prog_Len;
          pc_d  = '0;
          err_d = 1'b0;
          din_d = rd_data;
          run_d = 1'b1;
        end
      end
      ISSUE: begin
        run_d = 1'b0;
        if (is_mvi) begin
          if (is_last) begin
            err_d = 1'b1;
            din_d = '0;
          end else begin
            din_d = rd_data;
          end
        end
      end
      default: begin
        if (bus.Done) begin
          pc_d = next_pc;
          if (is_last) begin
            done_d = 1'b1;
            run_d  = 1'b0;
            din_d  = '0;
          end else begin
            din_d = rd_data;
            run_d = 1'b1;
          end
        end else if (timed_out) begin
          err_d = 1'b1;
          run_d = 1'b0;
          din_d = '0;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      din_q  <= '0;
      run_q  <= 1'b0;
      pc_q   <= '0;
      len_q  <= '0;
      tcnt_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      din_q  <= din_d;
      run_q  <= run_d;
      pc_q   <= pc_d;
      len_q  <= len_d;
      tcnt_q <= tcnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign bus.DIN       = din_q;
  assign bus.Run       = run_q;
  assign bus.PC        = pc_q;
  assign bus.Busy      = state_q != IDLE;
  assign bus.Prog_Done = done_q;
  assign bus.Error     = err_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   pd_cnt = 0;
  int   pd0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.DW(9), .AW(5)) bus ();

  instr_sequencer #(.DW(9), .AW(5), .MVI_OP(3'b011), .TIMEOUT(16)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus.slave)
  );

  always @(posedge clk) if (bus.Prog_Done === 1'b1) pd_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [8:0] d);
    bus.Wr_En   = 1'b1;
    bus.Wr_Addr = 5'(a);
    bus.Wr_Data = d;
    step();
    bus.Wr_En   = 1'b0;
  endtask

  task automatic start(input int n);
    bus.Prog_Len = 6'(n);
    bus.Start    = 1'b1;
    step();
    bus.Start    = 1'b0;
  endtask

  initial begin
    bus.Wr_En = 0; bus.Wr_Addr = 0; bus.Wr_Data = 0;
    bus.Prog_Len = 0; bus.Start = 0; bus.Done = 0;
    step(); step();
    chk("rst_din", bus.DIN, 0);
    chk("rst_run", bus.Run, 0);
    chk("rst_pc", bus.PC, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_pdone", bus.Prog_Done, 0);
    chk("rst_err", bus.Error, 0);
    rst_n = 1'b1;
    step();

    // two mvi instructions, Done during each immediate cycle
    load(0, 9'h0C1); load(1, 9'h1CF); load(2, 9'h0D1); load(3, 9'h1FF);
    pd0 = pd_cnt;
    start(4);
    chk("mvi_iss1_din", bus.DIN, 9'h0C1);
    chk("mvi_iss1_run", bus.Run, 1);
    chk("mvi_iss1_busy", bus.Busy, 1);
    step();
    chk("mvi_imm1_din", bus.DIN, 9'h1CF);
    chk("mvi_imm1_run", bus.Run, 0);
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    chk("mvi_iss2_din", bus.DIN, 9'h0D1);
    chk("mvi_iss2_run", bus.Run, 1);
    chk("mvi_iss2_pc", bus.PC, 2);
    step();
    chk("mvi_imm2_din", bus.DIN, 9'h1FF);
    chk("mvi_imm2_run", bus.Run, 0);
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    chk("mvi_end_pdone", bus.Prog_Done, 1);
    chk("mvi_end_pc", bus.PC, 4);
    chk("mvi_end_run", bus.Run, 0);
    chk("mvi_end_busy", bus.Busy, 0);
    chk("mvi_end_din", bus.DIN, 0);
    step();
    chk("mvi_pdone_pulse", bus.Prog_Done, 0);
    chk("mvi_pdone_count", 32'(pd_cnt - pd0), 1);

    // single-word instruction, Done three cycles after issue
    load(0, 9'h00A);
    start(1);
    chk("one_iss_din", bus.DIN, 9'h00A);
    chk("one_iss_run", bus.Run, 1);
    step();
    chk("one_wait1_din", bus.DIN, 9'h00A);
    chk("one_wait1_run", bus.Run, 0);
    step();
    chk("one_wait2_din", bus.DIN, 9'h00A);
    chk("one_wait2_pdone", bus.Prog_Done, 0);
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    chk("one_end_pdone", bus.Prog_Done, 1);
    chk("one_end_pc", bus.PC, 1);
    chk("one_end_busy", bus.Busy, 0);

    // truncated mvi
    load(0, 9'h0C1);
    pd0 = pd_cnt;
    start(1);
    step();
    chk("trunc_err", bus.Error, 1);
    chk("trunc_run", bus.Run, 0);
    chk("trunc_busy", bus.Busy, 0);
    chk("trunc_din", bus.DIN, 0);
    step();
    chk("trunc_no_pdone", 32'(pd_cnt - pd0), 0);

    // timeout with Done held low
    load(0, 9'h00A);
    start(1);
    chk("tmo_err_cleared", bus.Error, 0);
    step();
    for (int i = 0; i < 15; i++) step();
    chk("tmo_err_early", bus.Error, 0);
    chk("tmo_busy_early", bus.Busy, 1);
    step();
    chk("tmo_err", bus.Error, 1);
    chk("tmo_din", bus.DIN, 0);
    chk("tmo_busy", bus.Busy, 0);
    start(1);
    chk("tmo_restart_err", bus.Error, 0);
    step();

    // write and start while busy are ignored; async reset mid-WAIT
    bus.Wr_En = 1'b1; bus.Wr_Addr = 0; bus.Wr_Data = 9'h0C1;
    bus.Prog_Len = 4; bus.Start = 1'b1;
    step();
    bus.Wr_En = 1'b0; bus.Start = 1'b0;
    chk("busy_start_din", bus.DIN, 9'h00A);
    chk("busy_start_pc", bus.PC, 0);
    chk("busy_still", bus.Busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_din", bus.DIN, 0);
    chk("arst_run", bus.Run, 0);
    chk("arst_pc", bus.PC, 0);
    chk("arst_busy", bus.Busy, 0);
    #2 rst_n = 1'b1;
    step();
    start(1);
    chk("rerun_din", bus.DIN, 9'h00A);
    step();
    bus.Done = 1'b1;
    step();
    bus.Done = 1'b0;
    chk("rerun_pdone", bus.Prog_Done, 1);

    // zero-length program
    step();
    start(0);
    chk("zero_pdone", bus.Prog_Done, 1);
    chk("zero_run", bus.Run, 0);
    chk("zero_busy", bus.Busy, 0);
    step();
    chk("zero_pdone_pulse", bus.Prog_Done, 0);
    chk("zero_run_after", bus.Run, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program-side counterpart of simple_processor_Top: a loadable instruction store that drives the processor's DIN and Run and watches Done.
- Holds a short program of 9-bit words and issues them one instruction at a time.
- Supplies the immediate word in the cycle after an mvi opcode, and waits for Done before issuing the next instruction.
- Replaces hand-timed DIN stimulus in system-level benches and in FPGA top-levels.

Parameters:
- DW, 9, instruction/data word width; matches processor DIN.
- AW, 5, program address width; store depth is 2**AW words.
- MVI_OP, 3'b011, opcode value in DIN[DW-1:DW-3] that marks move-immediate (two-word instruction).
- TIMEOUT, 16, maximum cycles spent waiting for Done before aborting.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Wr_En  in  1  program-store write strobe; honoured only in IDLE.
- Wr_Addr  in  AW  program-store write address.
- Wr_Data  in  DW  program-store write data.
- Prog_Len  in  AW+1  number of program words (instruction plus immediate words); sampled on Start.
- Start  in  1  one-cycle pulse that begins execution from address 0.
- Done  in  1  processor instruction-complete flag.
- DIN  out  DW  word driven to the processor (registered).
- Run  out  1  processor Run (registered).
- PC  out  AW+1  address of the current instruction.
- Busy  out  1  high while not IDLE.
- Prog_Done  out  1  one-cycle pulse when the program completes normally.
- Error  out  1  sticky abort flag; cleared by the next accepted Start.

Behaviour:
- Reset (asynchronous, Resetn=0):
  - DIN=0, Run=0, PC=0, Busy=0, Prog_Done=0, Error=0, timeout counter=0, state IDLE.
  - Store contents are not reset.
  - Reset asserted mid-program aborts immediately to these values.
- States: IDLE, ISSUE, IMM, WAIT.
- IDLE:
  - Wr_En writes mem[Wr_Addr]=Wr_Data at the clock edge.
  - Start with Prog_Len=0: Prog_Done pulses next cycle; state stays IDLE.
  - Start with Prog_Len>0: latch length, PC=0, Error=0. Next edge: DIN=mem[0], Run=1, state ISSUE.
- ISSUE (exactly one cycle; the processor latches IR at this edge):
  - At the next edge Run=0.
  - If DIN[DW-1:DW-3]==MVI_OP and PC+1<len: DIN=mem[PC+1], state IMM.
  - If DIN[DW-1:DW-3]==MVI_OP and PC+1>=len (missing immediate): Error=1, DIN=0, state IDLE.
  - Otherwise: DIN holds, state WAIT.
- IMM and WAIT:
  - DIN holds; timeout counter increments each cycle; Done is sampled at every edge.
  - On Done=1: next PC = PC+2 if in IMM, PC+1 if in WAIT; counter clears.
  - If next PC>=len: Prog_Done pulses, Run=0, DIN=0, state IDLE.
  - Else: DIN=mem[next PC], Run=1, state ISSUE.
  - The next instruction therefore appears exactly one cycle after Done.
  - If the counter reaches TIMEOUT with no Done: Error=1, Run=0, DIN=0, state IDLE.
- Start while Busy: ignored. Wr_En while Busy: ignored; the store is unchanged.
- Done while in IDLE or ISSUE: ignored.
- PC compares are unsigned, width AW+1, so a full 2**AW-word program ends without wrap.
- Busy is 1 in every state except IDLE.

Decomposition:
- Shared package (processor-wide, also used by the processor's control unit):
  - state enum {IDLE, ISSUE, IMM, WAIT}
  - opcode field position constants
  - MVI_OP and the other opcode constants
  - DW
- Natural sub-module: instr_store, a register-array program memory with one synchronous write port and one combinational read port (AW, DW parameters).
- The FSM, PC and timeout counter stay in instr_sequencer.

Test Plan:
- Two mvi instructions: load {9'b011000001, 9'b111001111, 9'b011010001, 9'b111111111}, Prog_Len=4, Start; processor model asserts Done during the immediate cycle. Required:
  - DIN sequence 0C1h, 1CFh, 0D1h, 1FFh.
  - Run high only in the two ISSUE cycles.
  - Prog_Done pulses once; PC=4 at completion.
- Single-word instruction: load 9'b000001010, Prog_Len=1; model asserts Done 3 cycles after issue. Required: DIN holds 00Ah through WAIT; Prog_Done pulses the cycle after Done; no IMM state.
- Truncated mvi: program {9'b011000001}, Prog_Len=1. Required: Error=1 one cycle after ISSUE, Run=0, Busy=0, no Prog_Done.
- Timeout: Done tied low, TIMEOUT=16. Required: Error rises exactly 16 cycles after entering WAIT; DIN=0. The next Start clears Error.
- Reset and ignored inputs: Resetn pulsed low mid-WAIT. Required:
  - DIN, Run, PC, Busy all 0 immediately, without waiting for a clock edge.
  - A Wr_En issued while Busy does not alter the store (verified by a re-run).
  - Start during Busy has no effect.
- Prog_Len=0: Start gives a one-cycle Prog_Done and Run never asserts.
